// File: rtl/ps_bc_pkg.sv
// Shared codes for the program-sequencer bus-connect selects and the
// bus-connect FSM state encoding.
package ps_bc_pkg;

  localparam logic [1:0] DRR_DAG  = 2'b00;
  localparam logic [1:0] DRR_STK  = 2'b01;
  localparam logic [1:0] DRR_RF   = 2'b10;
  localparam logic [1:0] DRR_NONE = 2'b11;

  localparam logic [1:0] DI_DM    = 2'b00;
  localparam logic [1:0] DI_INT   = 2'b01;
  localparam logic [1:0] DI_IMM   = 2'b10;
  localparam logic [1:0] DI_IDLE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WAIT_DM = 2'b01,
    ST_TMO     = 2'b10
  } ps_bc_state_e;

endpackage

// File: rtl/ps_bc_src_mux.sv
// Combinational 4:1 source select driven by the registered drr code.
module ps_bc_src_mux
  import ps_bc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [1:0]        i_sel,
  input  logic [DATA_W-1:0] i_dag,
  input  logic [DATA_W-1:0] i_stk,
  input  logic [DATA_W-1:0] i_rf,
  output logic [DATA_W-1:0] o_dt
);

  always_comb begin
    o_dt = '0;
    case (i_sel)
      DRR_DAG:  o_dt = i_dag;
      DRR_STK:  o_dt = i_stk;
      DRR_RF:   o_dt = i_rf;
      DRR_NONE: o_dt = '0;
      default:  o_dt = '0;
    endcase
  end

endmodule

// File: rtl/ps_bus_connect.sv
// Bus-connect datapath: gathers the selected source, drives one registered word
// with a valid pulse, and stalls the sequencer while a DM read is outstanding.
module ps_bus_connect
  import ps_bc_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ps_bc_drr_slct,
  input  logic [1:0]        ps_bc_di_slct,
  input  logic [DATA_W-1:0] ps_imm_dt,
  input  logic [DATA_W-1:0] rf_rd_dt,
  input  logic [DATA_W-1:0] stk_rd_dt,
  input  logic [DATA_W-1:0] dag_rd_dt,
  input  logic [DATA_W-1:0] dm_rd_dt,
  input  logic              dm_rdy,
  output logic [DATA_W-1:0] ps_bc_dt,
  output logic              ps_bc_vld,
  output logic              ps_bc_stall,
  output logic              ps_bc_tmo
);

  ps_bc_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [1:0]        r_drr_q, w_drr_nxt;
  logic [DATA_W-1:0] r_dt, w_dt_nxt;
  logic              r_vld, w_vld_nxt;
  logic              r_stall, w_stall_nxt;
  logic              r_tmo, w_tmo_nxt;
  logic [DATA_W-1:0] w_src;

  ps_bc_src_mux #(.DATA_W(DATA_W)) u_src_mux (
    .i_sel (r_drr_q),
    .i_dag (dag_rd_dt),
    .i_stk (stk_rd_dt),
    .i_rf  (rf_rd_dt),
    .o_dt  (w_src)
  );

  // drr is frozen while stalled so it stays paired with the held instruction
  assign w_drr_nxt = r_stall ? r_drr_q : ps_bc_drr_slct;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dt_nxt    = r_dt;
    w_vld_nxt   = 1'b0;
    w_stall_nxt = r_stall;
    w_tmo_nxt   = r_tmo;
    case (r_state)
      ST_IDLE: begin
        case (ps_bc_di_slct)
          DI_IMM: begin
            w_dt_nxt  = ps_imm_dt;
            w_vld_nxt = 1'b1;
          end
          DI_INT: begin
            w_dt_nxt  = w_src;
            w_vld_nxt = 1'b1;
          end
          DI_DM: begin
            if (dm_rdy) begin
              w_dt_nxt  = dm_rd_dt;
              w_vld_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_WAIT_DM;
              w_stall_nxt = 1'b1;
              w_cnt_nxt   = CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
      ST_WAIT_DM: begin
        // ready on the last allowed cycle still wins over the timeout
        if (dm_rdy) begin
          w_dt_nxt    = dm_rd_dt;
          w_vld_nxt   = 1'b1;
          w_stall_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_W'(MAX_WAIT)) begin
          w_stall_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_TMO;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_TMO: begin
        w_tmo_nxt   = 1'b1;
        w_dt_nxt    = '0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_drr_q <= DRR_NONE;
      r_dt    <= '0;
      r_vld   <= 1'b0;
      r_stall <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_drr_q <= w_drr_nxt;
      r_dt    <= w_dt_nxt;
      r_vld   <= w_vld_nxt;
      r_stall <= w_stall_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  assign ps_bc_dt    = r_dt;
  assign ps_bc_vld   = r_vld;
  assign ps_bc_stall = r_stall;
  assign ps_bc_tmo   = r_tmo;

endmodule

// File: tb/tb_ps_bus_connect.sv
// Directed bench for ps_bus_connect; observations packed as {dt, vld, stall, tmo}.
module tb_ps_bus_connect;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        drr, di;
  logic [DATA_W-1:0] imm, rf, stk, dag, dm;
  logic              dm_rdy;
  logic [DATA_W-1:0] ps_bc_dt;
  logic              ps_bc_vld, ps_bc_stall, ps_bc_tmo;

  int n_tests = 0;
  int n_fail  = 0;

  ps_bus_connect #(.DATA_W(DATA_W), .MAX_WAIT(15), .CNT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .ps_bc_drr_slct (drr),
    .ps_bc_di_slct  (di),
    .ps_imm_dt      (imm),
    .rf_rd_dt       (rf),
    .stk_rd_dt      (stk),
    .dag_rd_dt      (dag),
    .dm_rd_dt       (dm),
    .dm_rdy         (dm_rdy),
    .ps_bc_dt       (ps_bc_dt),
    .ps_bc_vld      (ps_bc_vld),
    .ps_bc_stall    (ps_bc_stall),
    .ps_bc_tmo      (ps_bc_tmo)
  );

  always #5 clk = ~clk;

  wire [DATA_W+2:0] obs = {ps_bc_dt, ps_bc_vld, ps_bc_stall, ps_bc_tmo};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [DATA_W+2:0] exp;
    rst = 1'b0; drr = 2'b11; di = 2'b11; dm_rdy = 1'b0;
    imm = '0; rf = 16'h4567; stk = 16'h0123; dag = 16'h89AB; dm = '0;
    #12;
    exp = '0;
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL reset_init got=%h exp=%h", obs, exp); end
    rst = 1'b1;
    tick();
    di = 2'b10; imm = 16'h1234;
    tick();
    #2 rst = 1'b0;
    #1;
    exp = '0;
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL reset_async got=%h exp=%h", obs, exp); end
    // drr_q must be NONE right after reset: an internal transfer yields zero
    drr = 2'b01; di = 2'b01;
    #1 rst = 1'b1;
    tick();
    exp = {16'h0000, 3'b100};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL reset_drr_none got=%h exp=%h", obs, exp); end
    di = 2'b11;
    tick();
  endtask

  task automatic test_immediate();
    logic [DATA_W+2:0] exp;
    di = 2'b10; imm = 16'hA5C3;
    tick();
    exp = {16'hA5C3, 3'b100};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL imm_xfer got=%h exp=%h", obs, exp); end
    di = 2'b11;
    tick();
    exp = {16'hA5C3, 3'b000};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL imm_hold got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_internal();
    logic [1:0]        codes [4] = '{2'b01, 2'b10, 2'b00, 2'b11};
    logic [DATA_W-1:0] vals  [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'h0000};
    logic [DATA_W+2:0] exp;
    for (int i = 0; i < 4; i++) begin
      drr = codes[i]; di = 2'b11;
      tick();
      di = 2'b01;
      tick();
      exp = {vals[i], 3'b100};
      n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL internal_drr%0d got=%h exp=%h", codes[i], obs, exp); end
    end
    di = 2'b11;
    tick();
  endtask

  task automatic test_dm_wait();
    logic [DATA_W+2:0] exp;
    int stall_cnt = 0;
    di = 2'b00; dm_rdy = 1'b0;
    tick();
    di = 2'b11;
    if (ps_bc_stall) stall_cnt++;
    tick(); if (ps_bc_stall) stall_cnt++;
    tick(); if (ps_bc_stall) stall_cnt++;
    n_tests++;
    if (stall_cnt != 3) begin n_fail++; $display("FAIL dm_stall_cycles got=%0d exp=3", stall_cnt); end
    dm_rdy = 1'b1; dm = 16'hBEEF;
    tick();
    exp = {16'hBEEF, 3'b100};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL dm_capture got=%h exp=%h", obs, exp); end
    dm_rdy = 1'b0;
    tick();
    exp = {16'hBEEF, 3'b000};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL dm_single_pulse got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_dm_ready_now();
    logic [DATA_W+2:0] exp;
    di = 2'b00; dm_rdy = 1'b1; dm = 16'hCAFE;
    tick();
    exp = {16'hCAFE, 3'b100};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL dm_ready_now got=%h exp=%h", obs, exp); end
    di = 2'b11; dm_rdy = 1'b0;
    tick();
    exp = {16'hCAFE, 3'b000};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL dm_ready_now_idle got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_stall_freeze();
    logic [DATA_W+2:0] exp;
    drr = 2'b01; di = 2'b11;
    tick();
    di = 2'b00; dm_rdy = 1'b0;
    tick();
    drr = 2'b10; di = 2'b11;
    tick();
    tick();
    dm_rdy = 1'b1; dm = 16'h1111; di = 2'b01;
    tick();
    exp = {16'h1111, 3'b100};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL freeze_capture got=%h exp=%h", obs, exp); end
    dm_rdy = 1'b0;
    tick();
    exp = {16'h0123, 3'b100};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL freeze_drr_q got=%h exp=%h", obs, exp); end
    di = 2'b11;
    tick();
  endtask

  task automatic test_timeout();
    logic [DATA_W+2:0] exp;
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    tick();
    // ready on the final allowed wait cycle is captured, no timeout
    di = 2'b00; dm_rdy = 1'b0;
    tick();
    di = 2'b11;
    repeat (14) tick();
    exp = {16'h0000, 3'b010};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL tmo_edge_stall got=%h exp=%h", obs, exp); end
    dm_rdy = 1'b1; dm = 16'h7777;
    tick();
    exp = {16'h7777, 3'b100};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL tmo_edge_capture got=%h exp=%h", obs, exp); end
    dm_rdy = 1'b0;
    tick();
    // no ready at all
    di = 2'b00;
    tick();
    di = 2'b11;
    repeat (14) tick();
    exp = {16'h7777, 3'b010};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL tmo_wait_stall got=%h exp=%h", obs, exp); end
    tick();
    exp = {16'h7777, 3'b000};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL tmo_stall_drop got=%h exp=%h", obs, exp); end
    dm_rdy = 1'b1; dm = 16'h9999;
    tick();
    exp = {16'h0000, 3'b001};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL tmo_flag got=%h exp=%h", obs, exp); end
    dm_rdy = 1'b0;
    di = 2'b10; imm = 16'h2222;
    tick();
    exp = {16'h2222, 3'b101};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL tmo_sticky got=%h exp=%h", obs, exp); end
    di = 2'b11;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    logic [DATA_W+2:0] exp;
    di = 2'b00; dm_rdy = 1'b0;
    tick();
    di = 2'b11;
    #2 rst = 1'b0;
    #1;
    exp = '0;
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL rst_mid_wait got=%h exp=%h", obs, exp); end
    dm_rdy = 1'b1; dm = 16'h3333;
    #1 rst = 1'b1;
    tick();
    exp = '0;
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL late_rdy_ignored got=%h exp=%h", obs, exp); end
    dm_rdy = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DATA_W+2:0] exp;
    drr = 2'b10; di = 2'b11;
    tick();
    di = 2'b10; imm = 16'h5A5A;
    tick();
    exp = {16'h5A5A, 3'b100};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL b2b_first got=%h exp=%h", obs, exp); end
    di = 2'b01;
    tick();
    exp = {16'h4567, 3'b100};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL b2b_second got=%h exp=%h", obs, exp); end
    di = 2'b11;
    tick();
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_internal();
    test_dm_wait();
    test_dm_ready_now();
    test_stall_freeze();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
